// File: rtl/data_mem_arbiter_pkg.sv
// mem_arb_pkg: shared state, port-id and opcode encodings for the data memory arbiter and MA stage
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_MA = 1'b1;
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_STORE = 1'b1;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: IF/MA request ports and memory-side bus of the data memory arbiter
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata;
  logic              ma_ack;
  logic [DATA_W-1:0] ma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata,
    input  if_ack, if_rdata, ma_ack, ma_rdata, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata,
    output if_ack, if_rdata, ma_ack, ma_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter_timer.sv
// mem_lat_timer: loadable down-counter timing one memory access; first marks the opening cycle
module mem_lat_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done,
  output logic first
);
  localparam int CW = $clog2(MEM_LAT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= CW'(MEM_LAT - 1);
    else if (en && cnt != '0) cnt <= cnt - CW'(1);
  assign done = cnt == '0;
  assign first = cnt == CW'(MEM_LAT - 1);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between instruction fetch and memory-access stage
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int MEM_LAT = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   bus,
  output logic                busy
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  state_t            state, state_n;
  logic              port, lat_we, grant_ma, grant_if, done, first;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata, if_rdata, ma_rdata;
  logic [SW-1:0]     streak;
  // MA has priority until IF has watched MAX_STREAK MA grants in a row
  assign grant_ma = bus.ma_req && !(bus.if_req && streak == SW'(MAX_STREAK));
  assign grant_if = bus.if_req && !grant_ma;
  assign bus.if_rdata = if_rdata;
  assign bus.ma_rdata = ma_rdata;
  mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == IDLE && (grant_ma || grant_if)),
    .en(state == ACCESS),
    .done(done),
    .first(first)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (grant_ma || grant_if) ? ACCESS : IDLE;
      ACCESS:  state_n = done ? RESP : ACCESS;
      default: state_n = IDLE;
    endcase
    bus.mem_addr = state == ACCESS ? lat_addr : '0;
    bus.mem_wdata = state == ACCESS ? lat_wdata : '0;
    bus.mem_we = state == ACCESS && first && lat_we;
    bus.if_ack = state == RESP && port == PORT_IF;
    bus.ma_ack = state == RESP && port == PORT_MA;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      port <= PORT_IF;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      streak <= '0;
      if_rdata <= '0;
      ma_rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        if (grant_ma || grant_if) begin
          port <= grant_ma ? PORT_MA : PORT_IF;
          lat_we <= grant_ma && bus.ma_we == OP_STORE;
          lat_addr <= grant_ma ? bus.ma_addr : bus.if_addr;
          lat_wdata <= grant_ma ? bus.ma_wdata : '0;
        end
        streak <= (!bus.if_req || grant_if) ? '0 :
                  (streak != SW'(MAX_STREAK)) ? streak + SW'(1) : streak;
      end
      if (state == ACCESS && done && !lat_we) begin
        if (port == PORT_MA) ma_rdata <= bus.mem_rdata;
        else if_rdata <= bus.mem_rdata;
      end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed stimulus with queued expected acks/writes checked by a separate monitor
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;
  typedef struct {logic port; logic [15:0] ird; logic [15:0] mrd; int cyc;} ack_t;
  typedef struct {logic [7:0] addr; logic [15:0] data;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  logic exp_idle = 1'b0;
  logic done = 1'b0;
  logic prev_rst = 1'b1;
  logic [15:0] ird = '0;
  logic [15:0] mrd = '0;
  logic [15:0] mem [256];
  logic wr [256];
  ack_t aq [$];
  wr_t wq [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c;
  always #5 clk = ~clk;
  data_mem_arbiter_if bus ();
  data_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return a == 8'h3A ? 16'hBEEF : {~a, a};
  endfunction
  assign bus.mem_rdata = wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    for (int i = 0; i < 256; i++) wr[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_we) begin
        mem[bus.mem_addr] = bus.mem_wdata;
        wr[bus.mem_addr] = 1'b1;
      end
    end
  end
  initial begin
    ack_t e;
    wr_t w;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n && prev_rst) begin
        #1;
        checks++;
        if (bus.mem_we || bus.if_ack || bus.ma_ack || busy || bus.mem_addr != 0 || bus.mem_wdata != 0 ||
            bus.if_rdata != 0 || bus.ma_rdata != 0) begin
          errors++;
          $display("FAIL reset_outputs we=%b ifack=%b maack=%b busy=%b addr=%h wdata=%h ird=%h mrd=%h required all zero",
                   bus.mem_we, bus.if_ack, bus.ma_ack, busy, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.ma_rdata);
        end
      end else if (rst_n && !clk) begin
        if (exp_idle) begin
          checks++;
          if (busy || bus.mem_we || bus.if_ack || bus.ma_ack || bus.mem_addr != 0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d busy=%b we=%b ifack=%b maack=%b addr=%h required all zero",
                     cyc, busy, bus.mem_we, bus.if_ack, bus.ma_ack, bus.mem_addr);
          end
        end
        if (bus.if_ack || bus.ma_ack) begin
          checks++;
          if (aq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack cyc=%0d ifack=%b maack=%b required no ack", cyc, bus.if_ack, bus.ma_ack);
          end else begin
            e = aq.pop_front();
            if (bus.if_ack != (e.port == PORT_IF) || bus.ma_ack != (e.port == PORT_MA) || bus.if_rdata != e.ird ||
                bus.ma_rdata != e.mrd || cyc != e.cyc) begin
              errors++;
              $display("FAIL ack got ifack=%b maack=%b ird=%h mrd=%h cyc=%0d required port=%0d ird=%h mrd=%h cyc=%0d",
                       bus.if_ack, bus.ma_ack, bus.if_rdata, bus.ma_rdata, cyc, e.port, e.ird, e.mrd, e.cyc);
            end
          end
        end
        if (bus.mem_we) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write cyc=%0d addr=%h data=%h required no write", cyc, bus.mem_addr, bus.mem_wdata);
          end else begin
            w = wq.pop_front();
            if (bus.mem_addr != w.addr || bus.mem_wdata != w.data) begin
              errors++;
              $display("FAIL write got addr=%h data=%h required addr=%h data=%h", bus.mem_addr, bus.mem_wdata, w.addr, w.data);
            end
          end
        end
        if (done) begin
          checks++;
          if (aq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL leftover acks=%0d writes=%0d required 0 0", aq.size(), wq.size());
          end
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
      prev_rst = rst_n;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_acks(input int n);
    int got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      step();
      if (bus.if_ack || bus.ma_ack) got++;
    end
    if (got < n) begin
      $display("FAIL ack_timeout got=%0d required=%0d", got, n);
      $fatal(1, "ack wait expired");
    end
  endtask
  task automatic push_ack(input logic p, input int at);
    aq.push_back('{p, ird, mrd, at});
  endtask
  initial begin
    {bus.if_req, bus.ma_req, bus.ma_we} = '0;
    bus.if_addr = '0;
    bus.ma_addr = '0;
    bus.ma_wdata = '0;
    #3 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_idle = 1'b1;
    repeat (10) step();
    exp_idle = 1'b0;
    c = cyc;
    mrd = 16'hBEEF;
    push_ack(PORT_MA, c + 3);
    bus.ma_addr = 8'h3A;
    bus.ma_we = OP_LOAD;
    bus.ma_req = 1'b1;
    wait_acks(1);
    bus.ma_req = 1'b0;
    step();
    c = cyc;
    wq.push_back('{8'h10, 16'h1234});
    push_ack(PORT_MA, c + 3);
    bus.ma_addr = 8'h10;
    bus.ma_we = OP_STORE;
    bus.ma_wdata = 16'h1234;
    bus.ma_req = 1'b1;
    wait_acks(1);
    bus.ma_req = 1'b0;
    bus.ma_we = OP_LOAD;
    step();
    c = cyc;
    mrd = 16'h1234;
    push_ack(PORT_MA, c + 3);
    bus.ma_req = 1'b1;
    wait_acks(1);
    bus.ma_req = 1'b0;
    step();
    c = cyc;
    bus.if_addr = 8'h05;
    bus.ma_addr = 8'h06;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) begin
        ird = 16'hFA05;
        push_ack(PORT_IF, c + 3 + 4 * k);
      end else begin
        mrd = 16'hF906;
        push_ack(PORT_MA, c + 3 + 4 * k);
      end
    end
    bus.if_req = 1'b1;
    bus.ma_req = 1'b1;
    wait_acks(8);
    bus.if_req = 1'b0;
    bus.ma_req = 1'b0;
    step();
    wq.push_back('{8'h20, 16'h7777});
    bus.ma_addr = 8'h20;
    bus.ma_we = OP_STORE;
    bus.ma_wdata = 16'h7777;
    bus.ma_req = 1'b1;
    step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    ird = '0;
    mrd = '0;
    step();
    step();
    wq.push_back('{8'h20, 16'h7777});
    c = cyc;
    push_ack(PORT_MA, c + 3);
    rst_n = 1'b1;
    wait_acks(1);
    bus.ma_req = 1'b0;
    bus.ma_we = OP_LOAD;
    step();
    c = cyc;
    bus.ma_addr = 8'h40;
    bus.if_addr = 8'h41;
    mrd = 16'hBF40;
    push_ack(PORT_MA, c + 3);
    ird = 16'hBE41;
    push_ack(PORT_IF, c + 7);
    bus.ma_req = 1'b1;
    bus.if_req = 1'b1;
    step();
    bus.ma_req = 1'b0;
    wait_acks(2);
    bus.if_req = 1'b0;
    step();
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_no_summary");
    $fatal(1, "monitor did not finish");
  end
endmodule
